// File: rtl/gate_seq_ctrl.sv
// Sequencer for one LSTM gate: streams X/Y column weights into the gate RAMs,
// then runs one beginCalc per timestep and hands each gate result downstream.
module gate_seq_ctrl #(
    parameter int unsigned INPUT_SZ  = 16,
    parameter int unsigned HIDDEN_SZ = 16,
    parameter int unsigned QN        = 6,
    parameter int unsigned QM        = 11,
    parameter int unsigned TIMEOUT   = 1024,
    localparam int unsigned BITWIDTH        = QN + QM + 1,
    localparam int unsigned LAYER_BITWIDTH  = BITWIDTH * HIDDEN_SZ,
    localparam int unsigned ADDR_BITWIDTH_X = $clog2(INPUT_SZ),
    localparam int unsigned ADDR_BITWIDTH   = $clog2(HIDDEN_SZ),
    localparam int unsigned STEP_W          = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cfg_start,
    input  logic [STEP_W-1:0]          num_steps,
    input  logic                       wt_valid,
    input  logic [LAYER_BITWIDTH-1:0]  wt_data,
    output logic                       wt_ready,
    output logic                       writeEn_X,
    output logic                       writeEn_Y,
    output logic [ADDR_BITWIDTH_X-1:0] colAddressWrite_X,
    output logic [ADDR_BITWIDTH-1:0]   colAddressWrite_Y,
    output logic [LAYER_BITWIDTH-1:0]  weightMemInput_X,
    output logic [LAYER_BITWIDTH-1:0]  weightMemInput_Y,
    input  logic                       step_valid,
    output logic                       step_ready,
    output logic                       beginCalc,
    input  logic                       dataReady_gate,
    input  logic [LAYER_BITWIDTH-1:0]  gateOutput,
    output logic                       out_valid,
    output logic [LAYER_BITWIDTH-1:0]  out_data,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int unsigned CNT_W  = (ADDR_BITWIDTH_X > ADDR_BITWIDTH) ? ADDR_BITWIDTH_X : ADDR_BITWIDTH;
    localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_X, LOAD_Y, WAIT_STEP, CALC, HOLD_OUT, DONE
    } stateType;

    stateType                   state, stateNext;
    logic [STEP_W-1:0]          numStepsQ, numStepsNext;
    logic [STEP_W-1:0]          stepCnt, stepCntNext;
    logic [CNT_W-1:0]           colCnt, colCntNext;
    logic [WDOG_W-1:0]          wdog, wdogNext;
    logic                       wtReadyNext, writeEnXNext, writeEnYNext;
    logic [ADDR_BITWIDTH_X-1:0] colAddrXNext;
    logic [ADDR_BITWIDTH-1:0]   colAddrYNext;
    logic [LAYER_BITWIDTH-1:0]  memInXNext, memInYNext, outDataNext;
    logic                       stepReadyNext, beginCalcNext, outValidNext;
    logic                       busyNext, doneNext, errNext;

    // Every output is a flop; the comb block computes its value for the next cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            numStepsQ         <= '0;
            stepCnt           <= '0;
            colCnt            <= '0;
            wdog              <= '0;
            wt_ready          <= 1'b0;
            writeEn_X         <= 1'b0;
            writeEn_Y         <= 1'b0;
            colAddressWrite_X <= '0;
            colAddressWrite_Y <= '0;
            weightMemInput_X  <= '0;
            weightMemInput_Y  <= '0;
            step_ready        <= 1'b0;
            beginCalc         <= 1'b0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
        end else begin
            state             <= stateNext;
            numStepsQ         <= numStepsNext;
            stepCnt           <= stepCntNext;
            colCnt            <= colCntNext;
            wdog              <= wdogNext;
            wt_ready          <= wtReadyNext;
            writeEn_X         <= writeEnXNext;
            writeEn_Y         <= writeEnYNext;
            colAddressWrite_X <= colAddrXNext;
            colAddressWrite_Y <= colAddrYNext;
            weightMemInput_X  <= memInXNext;
            weightMemInput_Y  <= memInYNext;
            step_ready        <= stepReadyNext;
            beginCalc         <= beginCalcNext;
            out_valid         <= outValidNext;
            out_data          <= outDataNext;
            busy              <= busyNext;
            done              <= doneNext;
            err               <= errNext;
        end
    end

    always_comb begin
        stateNext     = state;
        numStepsNext  = numStepsQ;
        stepCntNext   = stepCnt;
        colCntNext    = colCnt;
        wdogNext      = wdog;
        writeEnXNext  = 1'b0;
        writeEnYNext  = 1'b0;
        colAddrXNext  = colAddressWrite_X;
        colAddrYNext  = colAddressWrite_Y;
        memInXNext    = weightMemInput_X;
        memInYNext    = weightMemInput_Y;
        stepReadyNext = 1'b0;
        beginCalcNext = 1'b0;
        outValidNext  = out_valid;
        outDataNext   = out_data;
        errNext       = err;

        case (state)
            IDLE: begin
                if (cfg_start) begin
                    numStepsNext = num_steps;
                    errNext      = 1'b0;
                    stepCntNext  = '0;
                    colCntNext   = '0;
                    wdogNext     = '0;
                    stateNext    = LOAD_X;
                end
            end
            LOAD_X: begin
                if (wt_valid) begin
                    writeEnXNext = 1'b1;
                    colAddrXNext = ADDR_BITWIDTH_X'(colCnt);
                    memInXNext   = wt_data;
                    if (colCnt == CNT_W'(INPUT_SZ - 1)) begin
                        colCntNext = '0;
                        stateNext  = LOAD_Y;
                    end else begin
                        colCntNext = colCnt + 1'b1;
                    end
                end
            end
            LOAD_Y: begin
                if (wt_valid) begin
                    writeEnYNext = 1'b1;
                    colAddrYNext = ADDR_BITWIDTH'(colCnt);
                    memInYNext   = wt_data;
                    if (colCnt == CNT_W'(HIDDEN_SZ - 1)) begin
                        colCntNext = '0;
                        stateNext  = (numStepsQ == '0) ? DONE : WAIT_STEP;
                    end else begin
                        colCntNext = colCnt + 1'b1;
                    end
                end
            end
            WAIT_STEP: begin
                if (step_valid) begin
                    stepReadyNext = 1'b1;
                    beginCalcNext = 1'b1;
                    wdogNext      = '0;
                    stateNext     = CALC;
                end
            end
            CALC: begin
                // A result arriving on the expiry cycle still counts as a capture.
                if (dataReady_gate) begin
                    outDataNext  = gateOutput;
                    outValidNext = 1'b1;
                    stateNext    = HOLD_OUT;
                end else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
                    errNext   = 1'b1;
                    stateNext = DONE;
                end else begin
                    wdogNext = wdog + 1'b1;
                end
            end
            HOLD_OUT: begin
                if (out_ready) begin
                    outValidNext = 1'b0;
                    stepCntNext  = stepCnt + 1'b1;
                    stateNext    = ((stepCnt + STEP_W'(1)) == numStepsQ) ? DONE : WAIT_STEP;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Status flags track the state being entered so they line up with it.
        wtReadyNext = (stateNext == LOAD_X) || (stateNext == LOAD_Y);
        busyNext    = (stateNext != IDLE);
        doneNext    = (stateNext == DONE);
    end

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Bench for gate_seq_ctrl: table of run scenarios plus a mid-load reset sequence;
// RAM writes are matched against a scoreboard of accepted weight beats.
module tb_gate_seq_ctrl;

    localparam int unsigned LW = 72;

    logic          clock, reset;
    logic          cfg_start;
    logic [15:0]   num_steps;
    logic          wt_valid;
    logic [LW-1:0] wt_data;
    logic          wt_ready;
    logic          writeEn_X, writeEn_Y;
    logic [1:0]    colAddressWrite_X, colAddressWrite_Y;
    logic [LW-1:0] weightMemInput_X, weightMemInput_Y;
    logic          step_valid, step_ready, beginCalc;
    logic          dataReady_gate;
    logic [LW-1:0] gateOutput;
    logic          out_valid;
    logic [LW-1:0] out_data;
    logic          out_ready;
    logic          busy, done, err;

    gate_seq_ctrl #(
        .INPUT_SZ(4), .HIDDEN_SZ(4), .QN(6), .QM(11), .TIMEOUT(8)
    ) dut (
        .clock(clock), .reset(reset), .cfg_start(cfg_start), .num_steps(num_steps),
        .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
        .writeEn_X(writeEn_X), .writeEn_Y(writeEn_Y),
        .colAddressWrite_X(colAddressWrite_X), .colAddressWrite_Y(colAddressWrite_Y),
        .weightMemInput_X(weightMemInput_X), .weightMemInput_Y(weightMemInput_Y),
        .step_valid(step_valid), .step_ready(step_ready), .beginCalc(beginCalc),
        .dataReady_gate(dataReady_gate), .gateOutput(gateOutput),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        bit            isY;
        int            col;
        logic [LW-1:0] data;
        int            cyc;
    } wrT;

    typedef struct {
        int            numSteps;
        bit            gap;
        int            latency;   // cycles from beginCalc to dataReady_gate; 0 = never
        int            hold;      // cycles out_ready stays low in HOLD_OUT
        logic [LW-1:0] dataBase;
        logic [LW-1:0] gateBase;
        bit            expErr;
        int            expBegins;
    } vecT;

    wrT  sb[$];
    vecT vecs[6];
    int  nChecks = 0;
    int  nPass = 0;
    int  cycleCnt = 0;
    int  beginCnt = 0;
    int  doneCnt = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Every RAM write must match the oldest accepted beat and land one cycle after it.
    always @(negedge clock) begin
        if (beginCalc) beginCnt <= beginCnt + 1;
        if (done) doneCnt <= doneCnt + 1;
        if (writeEn_X || writeEn_Y) begin
            chk("write pending", 256'(sb.size() != 0), 256'(1));
            if (sb.size() != 0) begin
                wrT e;
                e = sb.pop_front();
                chk("write",
                    256'({writeEn_X, writeEn_Y,
                          (writeEn_Y ? colAddressWrite_Y : colAddressWrite_X),
                          (writeEn_Y ? weightMemInput_Y : weightMemInput_X), cycleCnt}),
                    256'({~e.isY, e.isY, 2'(e.col), e.data, e.cyc}));
            end
        end
    end

    task automatic driveBeat(input int k, input logic [LW-1:0] d, output bit ok);
        int guard;
        bit acc;
        wt_valid = 1'b1;
        wt_data  = d;
        guard = 0;
        acc = 1'b0;
        while (!acc && guard < 20) begin
            acc = wt_ready;
            tick();
            guard++;
        end
        chk("beat accept", 256'(acc), 256'(1));
        ok = acc;
        if (acc) sb.push_back('{isY: (k >= 4), col: (k % 4), data: d, cyc: cycleCnt});
    endtask

    task automatic runScenario(input vecT v);
        logic [LW-1:0] val;
        bit ok, timedOut, last;
        int beginStart, doneStart;
        beginStart = beginCnt;
        doneStart  = doneCnt;

        cfg_start = 1'b1;
        num_steps = 16'(v.numSteps);
        tick();
        cfg_start = 1'b0;
        chk("start flags", 256'({busy, wt_ready, err, done}), 256'(4'b1100));

        for (int k = 0; k < 8; k++) begin
            driveBeat(k, v.dataBase + LW'(k), ok);
            if (!ok) begin
                wt_valid = 1'b0;
                return;
            end
            if (v.gap && k < 7) begin
                wt_valid = 1'b0;
                tick();
            end
        end
        wt_valid = 1'b0;

        if (v.numSteps == 0) begin
            chk("load end", 256'({wt_ready, busy, done}), 256'(3'b011));
            tick();
            chk("idle after done", 256'({busy, done}), 256'(2'b00));
        end else begin
            chk("load end", 256'({wt_ready, busy, done}), 256'(3'b010));
            timedOut = 1'b0;
            for (int s = 0; s < v.numSteps && !timedOut; s++) begin
                val = v.gateBase + LW'(s) * LW'('h11);
                tick();
                chk("no begin while waiting", 256'({beginCalc, step_ready}), 256'(2'b00));
                step_valid = 1'b1;
                tick();
                step_valid = 1'b0;
                chk("begin pulse", 256'({beginCalc, step_ready}), 256'(2'b11));
                if (v.latency == 0) begin
                    for (int c = 1; c <= 7; c++) begin
                        tick();
                        if (c == 1) chk("begin single", 256'({beginCalc, step_ready}), 256'(2'b00));
                    end
                    chk("pre expiry", 256'({err, done}), 256'(2'b00));
                    tick();
                    chk("expiry", 256'({err, done, out_valid}), 256'(3'b110));
                    tick();
                    chk("after expiry", 256'({busy, done, err}), 256'(3'b001));
                    timedOut = 1'b1;
                end else begin
                    for (int c = 1; c <= v.latency; c++) begin
                        tick();
                        if (c == 1) chk("begin single", 256'({beginCalc, step_ready}), 256'(2'b00));
                    end
                    dataReady_gate = 1'b1;
                    gateOutput     = val;
                    tick();
                    dataReady_gate = 1'b0;
                    gateOutput     = '1;
                    chk("capture", 256'({out_valid, err, out_data}), 256'({2'b10, val}));
                    for (int h = 0; h < v.hold; h++) begin
                        step_valid     = 1'b1;
                        dataReady_gate = 1'b1;
                        gateOutput     = ~val;
                        cfg_start      = 1'b1;
                        out_ready      = 1'b0;
                        tick();
                        chk("hold", 256'({out_valid, out_data, beginCalc, step_ready, busy}),
                            256'({1'b1, val, 3'b001}));
                    end
                    step_valid     = 1'b0;
                    dataReady_gate = 1'b0;
                    cfg_start      = 1'b0;
                    out_ready      = 1'b1;
                    tick();
                    out_ready = 1'b0;
                    last = (s == v.numSteps - 1);
                    chk("handshake", 256'({out_valid, done, busy}), 256'({1'b0, last, 1'b1}));
                    if (last) begin
                        tick();
                        chk("after done", 256'({busy, done, out_valid}), 256'(3'b000));
                    end
                end
            end
        end
        chk("err", 256'(err), 256'(v.expErr));
        chk("begin count", 256'(beginCnt - beginStart), 256'(v.expBegins));
        chk("done count", 256'(doneCnt - doneStart), 256'(1));
        chk("writes drained", 256'(sb.size()), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        //            steps gap lat hold dataBase                 gateBase  err begins
        vecs[0] = '{2, 1'b0, 5, 0,  LW'(1),                  LW'('hA5), 1'b0, 2};
        vecs[1] = '{3, 1'b1, 5, 0,  LW'('h12_3456_789A_BCDE_F011), LW'('hA5), 1'b0, 3};
        vecs[2] = '{1, 1'b0, 1, 10, LW'('h40),               LW'('h5A5A5), 1'b0, 1};
        vecs[3] = '{1, 1'b0, 7, 0,  LW'('h80),               LW'('h33), 1'b0, 1};
        vecs[4] = '{2, 1'b0, 0, 0,  LW'('h100),              LW'('h77), 1'b1, 1};
        vecs[5] = '{0, 1'b1, 0, 0,  LW'('h200),              LW'('h0), 1'b0, 0};

        reset = 1'b0;
        cfg_start = 1'b0;
        num_steps = '0;
        wt_valid = 1'b0;
        wt_data = '0;
        step_valid = 1'b0;
        dataReady_gate = 1'b0;
        gateOutput = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset outputs", 256'({wt_ready, writeEn_X, writeEn_Y, colAddressWrite_X, colAddressWrite_Y,
                                   weightMemInput_X, weightMemInput_Y, step_ready, beginCalc,
                                   out_valid, out_data, busy, done, err}), 256'(0));
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk("idle after reset", 256'({wt_ready, busy}), 256'(2'b00));

        for (int i = 0; i < 6; i++) runScenario(vecs[i]);

        // Reset while LOAD_Y is about to take beat 2.
        cfg_start = 1'b1;
        num_steps = 16'd1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 6; k++) driveBeat(k, LW'('h300 + k), ok);
        wt_valid = 1'b0;
        tick();
        chk("in load_y", 256'({wt_ready, busy}), 256'(2'b11));
        wt_valid = 1'b1;
        wt_data  = LW'('h306);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset", 256'({wt_ready, writeEn_X, writeEn_Y, colAddressWrite_X, colAddressWrite_Y,
                                 weightMemInput_X, weightMemInput_Y, step_ready, beginCalc,
                                 out_valid, out_data, busy, done, err}), 256'(0));
        @(posedge clock);
        #3;
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("idle until start", 256'({wt_ready, busy, writeEn_X, writeEn_Y}), 256'(4'b0000));
        end
        wt_valid = 1'b0;
        chk("writes after reset", 256'(sb.size()), 256'(0));

        runScenario(vecs[0]);

        repeat (2) tick();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
